// File: rtl/axi_mem_slave.sv
// AXI memory slave (AR/R/AW/W subset) backed by a synchronous word RAM.
// One transaction at a time; read data returns READ_LATENCY edges after the AR handshake.
module axi_mem_slave #(
    parameter int unsigned WORDS_LOG2   = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic        RVALID,
    output logic [31:0] RDATA,
    input  logic        RREADY,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic        WLAST
);

    localparam int unsigned Depth = 1 << WORDS_LOG2;

    typedef enum logic [1:0] {StIdle, StRead, StRdata, StWrite} state_e;

    state_e                state_q, state_d;
    logic [WORDS_LOG2-1:0] idx_q;
    logic [3:0]            cnt_q;
    logic                  rvalid_q;
    logic [31:0]           rdata_q;
    logic                  wready_q;
    logic [31:0]           mem [Depth];

    logic ar_hs, aw_hs, r_hs, w_hs, mem_we;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    state_d = StRead;
                end else if (aw_hs) begin
                    state_d = StWrite;
                end
            end
            StRead:  if (cnt_q == 4'd0) state_d = StRdata;
            StRdata: if (r_hs) state_d = StIdle;
            StWrite: if (w_hs && WLAST) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs and handshakes; AR wins over AW when both are valid in idle
    always_comb begin
        ARREADY = (state_q == StIdle);
        AWREADY = (state_q == StIdle) && !ARVALID;
        RVALID  = rvalid_q;
        RDATA   = rdata_q;
        WREADY  = wready_q;
        ar_hs   = ARVALID && ARREADY;
        aw_hs   = AWVALID && AWREADY;
        r_hs    = rvalid_q && RREADY;
        w_hs    = (state_q == StWrite) && WVALID && wready_q;
        mem_we  = w_hs && !RST;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            wready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ar_hs) begin
                        idx_q <= ARADDR[WORDS_LOG2+1:2];
                        cnt_q <= 4'(READ_LATENCY - 1);
                    end else if (aw_hs) begin
                        idx_q <= AWADDR[WORDS_LOG2+1:2];
                    end
                end
                StRead: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q  <= mem[idx_q];
                        rvalid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRdata: begin
                    if (r_hs) rvalid_q <= 1'b0;
                end
                StWrite: begin
                    // WREADY rises one cycle after entry, then gates every beat
                    if (!wready_q) begin
                        wready_q <= 1'b1;
                    end else if (w_hs) begin
                        idx_q <= idx_q + WORDS_LOG2'(1);
                        if (WLAST) wready_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM is deliberately left out of reset so partial bursts survive it
    always_ff @(posedge CLK) begin
        if (mem_we) mem[idx_q] <= WDATA;
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave (small RAM to exercise address wrap).
module tb_axi_mem_slave;

    localparam int unsigned WordsLog2 = 4;
    localparam int unsigned ReadLat   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, wlast;

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;
    logic [31:0] wbuf [4];
    logic [31:0] rd;
    int          lat;

    axi_mem_slave #(
        .WORDS_LOG2  (WordsLog2),
        .READ_LATENCY(ReadLat)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .ARADDR (araddr),
        .ARVALID(arvalid),
        .ARREADY(arready),
        .RVALID (rvalid),
        .RDATA  (rdata),
        .RREADY (rready),
        .AWADDR (awaddr),
        .AWVALID(awvalid),
        .AWREADY(awready),
        .WDATA  (wdata),
        .WVALID (wvalid),
        .WREADY (wready),
        .WLAST  (wlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (at negedges) until sig is 1; counts a failure on timeout.
    task automatic wait_high(input string tag, input int which);
        int n;
        logic s;
        n = 0;
        forever begin
            case (which)
                0: s = arready;
                1: s = awready;
                2: s = wready;
                default: s = rvalid;
            endcase
            if (s === 1'b1) break;
            if (n == 50) begin
                check({tag, "_timeout"}, 32'd0, 32'd1);
                break;
            end
            n++;
            @(negedge clk);
        end
    endtask

    // Writes n beats of wbuf starting at addr; WLAST marks beat total-1.
    task automatic write_burst(input logic [31:0] addr, input int n, input int total);
        @(negedge clk);
        awaddr  = addr;
        awvalid = 1'b1;
        wait_high("aw", 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wdata  = wbuf[i];
            wvalid = 1'b1;
            wlast  = (i == total - 1);
            wait_high("w", 2);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    // Full read with RREADY high; returns data and edges from AR handshake to RVALID.
    task automatic read_word(input logic [31:0] addr, output logic [31:0] data, output int l);
        int th;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        wait_high("ar", 0);
        th = cyc + 1;
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        wait_high("r", 3);
        l    = cyc - th;
        data = rdata;
        @(negedge clk);
        rready = 1'b0;
        check("arready_after_r", {31'd0, arready}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        read_word(addr, rd, lat);
        check(tag, rd, exp);
    endtask

    initial begin
        rst = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; wlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_awready", {31'd0, awready}, 32'd1);
        arvalid = 1'b1;
        #1 check("rst_awready_arv", {31'd0, awready}, 32'd0);
        arvalid = 1'b0;
        rst = 1'b0;

        // Write then read, with latency measured
        wbuf[0] = 32'hDEAD_BEEF;
        write_burst(32'h10, 1, 1);
        check("single_wready_drop", {31'd0, wready}, 32'd0);
        read_word(32'h10, rd, lat);
        check("single_data", rd, 32'hDEAD_BEEF);
        check("read_latency", lat, ReadLat);

        // 4-beat burst at 0x100 (word 0 in a 16-word RAM)
        wbuf = '{32'h11, 32'h22, 32'h33, 32'h44};
        write_burst(32'h100, 4, 4);
        check("burst_wready_drop", {31'd0, wready}, 32'd0);
        read_check("burst0", 32'h100, 32'h11);
        read_check("burst1", 32'h104, 32'h22);
        read_check("burst2", 32'h108, 32'h33);
        read_check("burst3", 32'h10C, 32'h44);
        check("burst_latency", lat, ReadLat);

        // Address wrap: 0x40 aliases word 0; burst from 0x3C wraps to word 0
        wbuf[0] = 32'hA5;
        write_burst(32'h40, 1, 1);
        read_check("wrap_alias", 32'h0, 32'hA5);
        wbuf[0] = 32'hB1; wbuf[1] = 32'hB2;
        write_burst(32'h3C, 2, 2);
        read_check("wrap_beat0", 32'h3C, 32'hB1);
        read_check("wrap_beat1", 32'h0, 32'hB2);
        read_check("wrap_keep1", 32'h4, 32'h22);

        // Simultaneous AR and AW: read first, AW after R handshake
        @(negedge clk);
        araddr = 32'h10; arvalid = 1'b1;
        awaddr = 32'h20; awvalid = 1'b1;
        #1;
        check("sim_arready", {31'd0, arready}, 32'd1);
        check("sim_awready", {31'd0, awready}, 32'd0);
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        check("sim_busy_awready", {31'd0, awready}, 32'd0);
        wait_high("sim_r", 3);
        check("sim_rdata", rdata, 32'hDEAD_BEEF);
        check("sim_rdata_awready", {31'd0, awready}, 32'd0);
        @(negedge clk);
        rready = 1'b0;
        check("sim_awready_after", {31'd0, awready}, 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        wdata = 32'h5A; wvalid = 1'b1; wlast = 1'b1;
        wait_high("sim_w", 2);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        read_check("sim_wdata", 32'h20, 32'h5A);

        // R back-pressure for 10 cycles
        @(negedge clk);
        araddr = 32'h104; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        wait_high("bp_r", 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rvalid", {31'd0, rvalid}, 32'd1);
            check("bp_rdata", rdata, 32'h22);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("bp_rvalid_drop", {31'd0, rvalid}, 32'd0);
        check("bp_arready", {31'd0, arready}, 32'd1);

        // Reset during a pending read
        @(negedge clk);
        araddr = 32'h10; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rrst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rrst_wready", {31'd0, wready}, 32'd0);
        check("rrst_arready", {31'd0, arready}, 32'd1);
        repeat (ReadLat + 2) @(negedge clk);
        check("rrst_no_rvalid", {31'd0, rvalid}, 32'd0);
        rready = 1'b0;

        // Reset after beat 2 of a 4-beat burst
        wbuf = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        write_burst(32'h20, 4, 4);
        wbuf = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
        write_burst(32'h20, 2, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wrst_rvalid", {31'd0, rvalid}, 32'd0);
        check("wrst_wready", {31'd0, wready}, 32'd0);
        check("wrst_arready", {31'd0, arready}, 32'd1);
        read_check("wrst_beat0", 32'h20, 32'hD0);
        read_check("wrst_beat1", 32'h24, 32'hD1);
        read_check("wrst_beat2", 32'h28, 32'hC2);
        read_check("wrst_beat3", 32'h2C, 32'hC3);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
